mem_arbiter: RTL

Arbiter that shares one single-ported unified memory between the core's instruction-fetch port and its load/store port. It accepts a request from at most one requester per grant, drives the memory port, tracks the fixed read latency, and routes registered read data back to the owning requester. It sits between the core's fetch/load-store logic and the memory macro, replacing separate instruction/data memories.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one single-ported memory between the
//            instruction-fetch and load/store ports, with fixed read latency.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int c_CW = $clog2(LAT + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_lat_cnt;
  logic            r_owner;
  logic            r_last_winner;
  logic            r_if_rvalid;
  logic            r_d_rvalid;
  logic [DW-1:0]   r_if_rdata;
  logic [DW-1:0]   r_d_rdata;

  logic w_grant_ok;
  logic w_if_win;
  logic w_d_win;

  // Reset gating keeps every grant and memory strobe low while rst is held.
  assign w_grant_ok = (r_state == S_IDLE) && !rst;
  assign w_if_win   = w_grant_ok && if_req && (!d_req || r_last_winner);
  assign w_d_win    = w_grant_ok && d_req && (!if_req || !r_last_winner);

  assign if_gnt    = w_if_win;
  assign d_gnt     = w_d_win;
  assign mem_en    = w_if_win | w_d_win;
  assign mem_we    = w_d_win & d_we;
  assign mem_addr  = w_if_win ? if_addr : (w_d_win ? d_addr : '0);
  assign mem_wdata = w_d_win ? d_wdata : '0;

  assign busy      = (r_state == S_BUSY);
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_lat_cnt     <= '0;
      r_owner       <= 1'b0;
      r_last_winner <= 1'b1;
      r_if_rvalid   <= 1'b0;
      r_d_rvalid    <= 1'b0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_if_win) begin
            r_last_winner <= 1'b0;
            r_owner       <= 1'b0;
            r_lat_cnt     <= c_CW'(LAT);
            r_state       <= S_BUSY;
          end else if (w_d_win) begin
            r_last_winner <= 1'b1;
            // Writes finish in the grant cycle; only reads occupy the port.
            if (!d_we) begin
              r_owner   <= 1'b1;
              r_lat_cnt <= c_CW'(LAT);
              r_state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (r_lat_cnt == c_CW'(1)) begin
            r_lat_cnt <= '0;
            r_state   <= S_IDLE;
            if (r_owner) begin
              r_d_rdata  <= mem_rdata;
              r_d_rvalid <= 1'b1;
            end else begin
              r_if_rdata  <= mem_rdata;
              r_if_rvalid <= 1'b1;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - c_CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
